// File: rtl/fpu_norm_round.sv
// fpu_norm_round: single-precision normalise / denormalise / round stage.
// Sits between the add/mul mantissa datapath and the pack stage. Takes an
// unnormalised {sign, exponent, mantissa, guard, round, sticky}, then:
//   - shifts left until the hidden bit [23] is set or the exponent hits -126,
//   - shifts right while the exponent is below -126,
//   - rounds to nearest, ties to even.
// The result goes out with a 10-bit signed exponent and a 27-bit mantissa
// {3'b000, m[23:0]}. Exponent overflow and the -0 fix are left to pack.
//
// Build option: define FPU_NORM_ROUND_FAST_SHIFT_EN to replace the iterative
// one-bit-per-cycle left shift with a single-cycle leading-zero-count shift.
// The results are bit-identical; only the latency changes.
//
// Handshake: a beat moves across an interface on a rising clk edge where
// valid && ready are both high. Once out_valid is raised, it and z_*_out hold
// steady until out_ready is seen. in_ready is high only while the stage is idle.
module fpu_norm_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_s,
  input  logic [9:0]  in_e,
  input  logic [23:0] in_m,
  input  logic        in_g,
  input  logic        in_r,
  input  logic        in_st,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        z_s_out,
  output logic [9:0]  z_e_out,
  output logic [26:0] z_m_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NORM_L = 3'd1,
    NORM_R = 3'd2,
    ROUND  = 3'd3,
    OUT    = 3'd4
  } state_t;

  // Smallest normal exponent; also the exponent used for denormals.
  localparam logic signed [9:0] E_MIN = -10'sd126;

  state_t            state_q, state_d;
  logic              s_q, s_d;
  logic signed [9:0] e_q, e_d;
  logic [23:0]       m_q, m_d;
  logic              g_q, g_d;
  logic              r_q, r_d;
  logic              st_q, st_d;
  logic              first_q, first_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              z_s_q, z_s_d;
  logic [9:0]        z_e_q, z_e_d;
  logic [23:0]       z_m_q, z_m_d;

  logic              is_zero;
  logic              rnd_up;

  assign is_zero = ({m_q, g_q, r_q} == 26'd0);
  assign rnd_up  = g_q & (r_q | st_q | m_q[0]);

`ifdef FPU_NORM_ROUND_FAST_SHIFT_EN
  // Count the leading zeros of {m, g, r}; 26 means the vector is all zero.
  function automatic logic [4:0] lzc26(input logic [25:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 25; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  logic [4:0]         lz;
  logic signed [10:0] head;
  logic [4:0]         sh;
  logic [25:0]        vec_sh;

  // Whole left shift in one step, clamped so the exponent stops at -126.
  always_comb begin
    lz   = lzc26({m_q, g_q, r_q});
    head = {e_q[9], e_q} + 11'sd126;
    if (head <= 11'sd0) begin
      sh = 5'd0;
    end else if (head < $signed({6'd0, lz})) begin
      sh = head[4:0];
    end else begin
      sh = lz;
    end
    vec_sh = {m_q, g_q, r_q} << sh;
  end
`endif

  // Next-state and datapath logic for the whole stage.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    e_d         = e_q;
    m_d         = m_q;
    g_d         = g_q;
    r_d         = r_q;
    st_d        = st_q;
    first_d     = first_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    z_s_d       = z_s_q;
    z_e_d       = z_e_q;
    z_m_d       = z_m_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d        = in_s;
          e_d        = $signed(in_e);
          m_d        = in_m;
          g_d        = in_g;
          r_d        = in_r;
          st_d       = in_st;
          first_d    = 1'b1;
          in_ready_d = 1'b0;
          state_d    = NORM_L;
        end
      end

      NORM_L: begin
        first_d = 1'b0;
`ifdef FPU_NORM_ROUND_FAST_SHIFT_EN
        if (first_q && is_zero) begin
          e_d = E_MIN;
        end else begin
          e_d = e_q - $signed({5'd0, sh});
          m_d = vec_sh[25:2];
          g_d = vec_sh[1];
          r_d = vec_sh[0];
        end
        state_d = NORM_R;
`else
        if (first_q && is_zero) begin
          // A zero value has no hidden bit to find; park it at the denormal exponent.
          e_d     = E_MIN;
          state_d = NORM_R;
        end else if (!m_q[23] && (e_q > E_MIN)) begin
          e_d = e_q - 10'sd1;
          m_d = {m_q[22:0], g_q};
          g_d = r_q;
          r_d = 1'b0;
        end else begin
          state_d = NORM_R;
        end
`endif
      end

      NORM_R: begin
        if (e_q < E_MIN) begin
          // Bits falling off the round position collapse into sticky.
          e_d  = e_q + 10'sd1;
          m_d  = {1'b0, m_q[23:1]};
          g_d  = m_q[0];
          r_d  = g_q;
          st_d = st_q | r_q;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        z_s_d = s_q;
        if (rnd_up && (m_q == 24'hFFFFFF)) begin
          z_m_d = 24'h800000;
          z_e_d = e_q + 10'sd1;
        end else if (rnd_up) begin
          z_m_d = m_q + 24'd1;
          z_e_d = e_q;
        end else begin
          z_m_d = m_q;
          z_e_d = e_q;
        end
        out_valid_d = 1'b1;
        state_d     = OUT;
      end

      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State register; reset abandons any beat in flight and clears the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_q         <= 1'b0;
      e_q         <= '0;
      m_q         <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      st_q        <= 1'b0;
      first_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      z_s_q       <= 1'b0;
      z_e_q       <= '0;
      z_m_q       <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      e_q         <= e_d;
      m_q         <= m_d;
      g_q         <= g_d;
      r_q         <= r_d;
      st_q        <= st_d;
      first_q     <= first_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      z_s_q       <= z_s_d;
      z_e_q       <= z_e_d;
      z_m_q       <= z_m_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z_s_out   = z_s_q;
  assign z_e_out   = z_e_q;
  assign z_m_out   = {3'b000, z_m_q};

endmodule

// File: tb/tb_fpu_norm_round.sv
// tb_fpu_norm_round: randomized and directed bench for fpu_norm_round.
// The reference model computes each result arithmetically: a leading-zero
// count clamped at exponent -126, a right shift whose lost bits fold into
// sticky, and then round-to-nearest-even. The latency comes from the same
// shift counts.
module tb_fpu_norm_round;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_s = 1'b0;
  logic [9:0]  in_e = '0;
  logic [23:0] in_m = '0;
  logic        in_g = 1'b0;
  logic        in_r = 1'b0;
  logic        in_st = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        z_s_out;
  logic [9:0]  z_e_out;
  logic [26:0] z_m_out;

  fpu_norm_round dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_s     (in_s),
    .in_e     (in_e),
    .in_m     (in_m),
    .in_g     (in_g),
    .in_r     (in_r),
    .in_st    (in_st),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z_s_out  (z_s_out),
    .z_e_out  (z_e_out),
    .z_m_out  (z_m_out)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Returns {s, e[9:0], m[23:0], latency[7:0]}.
  function automatic logic [42:0] model(input logic s, input logic [9:0] e_in,
                                        input logic [23:0] m_in, input logic g,
                                        input logic r, input logic st);
    longint      v;
    int          e;
    int          lz;
    int          k;
    int          j;
    int          lat;
    logic        stk;
    logic        found;
    logic [23:0] m24;
    logic        gg;
    logic        rr;
    logic [9:0]  e10;
    v   = longint'({38'd0, m_in, g, r});
    e   = int'($signed(e_in));
    stk = st;
    k   = 0;
    j   = 0;
    if (v == 0) begin
      e = -126;
    end else begin
      lz    = 0;
      found = 1'b0;
      for (int b = 25; b >= 0; b--) begin
        if (!found) begin
          if (v[b]) found = 1'b1;
          else      lz++;
        end
      end
      if (e > -126) begin
        k = (lz < e + 126) ? lz : e + 126;
        v = v << k;
        e = e - k;
      end
      if (e < -126) begin
        j = -126 - e;
        if (j >= 26) begin
          stk = stk | (v != 0);
          v   = 0;
        end else begin
          stk = stk | ((v & ((longint'(1) << j) - 1)) != 0);
          v   = v >> j;
        end
        e = -126;
      end
    end
    m24 = v[25:2];
    gg  = v[1];
    rr  = v[0];
    if (gg && (rr || stk || m24[0])) begin
      if (m24 == 24'hFFFFFF) begin
        m24 = 24'h800000;
        e   = e + 1;
      end else begin
        m24 = m24 + 24'd1;
      end
    end
`ifdef FPU_NORM_ROUND_FAST_SHIFT_EN
    lat = 4 + j;
`else
    lat = 4 + k + j;
`endif
    e10 = e[9:0];
    return {s, e10, m24, lat[7:0]};
  endfunction

  // ---------------- scoreboard ----------------
  // Entry: {s, e[9:0], m[23:0], due_cycle[31:0]}
  logic [66:0] exp_q[$];
  logic [66:0] h;
  logic [42:0] mr;
  logic        head_started = 1'b0;
  logic        just_popped = 1'b0;

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      head_started = 1'b0;
      just_popped  = 1'b0;
    end else begin
      if (just_popped) begin
        check("after_pop_out_valid", out_valid, 0);
        check("after_pop_in_ready", in_ready, 1);
        just_popped = 1'b0;
      end else if (exp_q.size() != 0) begin
        h = exp_q[0];
        if (out_valid) begin
          if (!head_started) begin
            check("latency", cyc, h[31:0]);
            head_started = 1'b1;
          end
          check("z_s_out", z_s_out, h[66]);
          check("z_e_out", z_e_out, h[65:56]);
          check("z_m_out", z_m_out, {3'b000, h[55:32]});
          check("busy_in_ready", in_ready, 0);
          if (out_ready) begin
            void'(exp_q.pop_front());
            head_started = 1'b0;
            just_popped  = 1'b1;
          end
        end else if (cyc == int'(h[31:0])) begin
          check("latency_missing_valid", out_valid, 1);
        end
      end else if (out_valid) begin
        check("spurious_out_valid", out_valid, 0);
      end
      if (in_valid && in_ready) begin
        mr = model(in_s, in_e, in_m, in_g, in_r, in_st);
        exp_q.push_back({mr[42:8], 32'(cyc) + {24'd0, mr[7:0]}});
      end
    end
  end

  // ---------------- output backpressure driver ----------------
  logic rand_bp = 1'b0;
  logic force_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    else         out_ready = force_ready;
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 after the beat is taken.
  task automatic send_beat(input logic s, input logic [9:0] e, input logic [23:0] m,
                           input logic g, input logic r, input logic st);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_s     = s;
    in_e     = e;
    in_m     = m;
    in_g     = g;
    in_r     = r;
    in_st    = st;
    @(negedge clk);
    while (!in_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) check({name, "_drain_timeout"}, exp_q.size(), 0);
    @(negedge clk);
    check({name, "_idle_in_ready"}, in_ready, 1);
    check({name, "_idle_out_valid"}, out_valid, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  localparam int LAT_LEFT1 =
`ifdef FPU_NORM_ROUND_FAST_SHIFT_EN
    4;
`else
    5;
`endif

  logic [37:0] cap;
  int          waited;
  int          ei;
  logic [23:0] mm;

  initial begin
    // Hand-computed values that pin the reference model itself.
    mr = model(1'b0, 10'd0, 24'h400000, 1'b1, 1'b0, 1'b0);
    check("pin_left_e", mr[41:32], 10'h3FF);
    check("pin_left_m", mr[31:8], 24'h800001);
    check("pin_left_lat", mr[7:0], LAT_LEFT1);
    mr = model(1'b0, 10'd0, 24'h800001, 1'b1, 1'b0, 1'b0);
    check("pin_tie_odd_m", mr[31:8], 24'h800002);
    mr = model(1'b0, 10'd0, 24'h800000, 1'b1, 1'b0, 1'b0);
    check("pin_tie_even_m", mr[31:8], 24'h800000);
    mr = model(1'b0, 10'd3, 24'hFFFFFF, 1'b1, 1'b1, 1'b0);
    check("pin_carry_e", mr[41:32], 10'd4);
    check("pin_carry_m", mr[31:8], 24'h800000);
    mr = model(1'b0, 10'h37E, 24'h800000, 1'b0, 1'b0, 1'b0);
    check("pin_denorm_e", mr[41:32], 10'h382);
    check("pin_denorm_m", mr[31:8], 24'h080000);
    check("pin_denorm_lat", mr[7:0], 8);
    mr = model(1'b1, 10'd5, 24'h000000, 1'b0, 1'b0, 1'b0);
    check("pin_zero_e", mr[41:32], 10'h382);
    check("pin_zero_m", mr[31:8], 24'h000000);
    check("pin_zero_s", mr[42], 1);

    // Reset.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_z_s", z_s_out, 0);
    check("reset_z_e", z_e_out, 0);
    check("reset_z_m", z_m_out, 0);
    @(posedge clk);
    #1;

    // Directed cases, downstream always ready.
    force_ready = 1'b1;
    send_beat(1'b0, 10'd0,   24'h400000, 1'b1, 1'b0, 1'b0);  wait_idle("left_norm");
    send_beat(1'b0, 10'd0,   24'h800001, 1'b1, 1'b0, 1'b0);  wait_idle("tie_odd");
    send_beat(1'b0, 10'd0,   24'h800000, 1'b1, 1'b0, 1'b0);  wait_idle("tie_even");
    send_beat(1'b0, 10'd3,   24'hFFFFFF, 1'b1, 1'b1, 1'b0);  wait_idle("round_carry");
    send_beat(1'b0, 10'h37E, 24'h800000, 1'b0, 1'b0, 1'b0);  wait_idle("denorm");
    send_beat(1'b1, 10'h382, 24'h123456, 1'b1, 1'b1, 1'b0);  wait_idle("at_emin");
    send_beat(1'b0, 10'h2D4, 24'hFFFFFF, 1'b1, 1'b1, 1'b1);  wait_idle("deep_denorm");
    send_beat(1'b0, 10'd100, 24'h000000, 1'b0, 1'b1, 1'b0);  wait_idle("only_r");
    send_beat(1'b0, 10'h338, 24'h000000, 1'b0, 1'b0, 1'b1);  wait_idle("zero_low_e");
    send_beat(1'b1, 10'h384, 24'h000001, 1'b1, 1'b0, 1'b0);  wait_idle("clamp_left");

    // Zero with backpressure: outputs must hold while out_ready is low.
    force_ready = 1'b0;
    @(posedge clk);
    #1;
    send_beat(1'b1, 10'd5, 24'h000000, 1'b0, 1'b0, 1'b0);
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("bp_valid_seen", out_valid, 1);
    cap = {z_s_out, z_e_out, z_m_out};
    repeat (10) @(negedge clk);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_in_ready", in_ready, 0);
    check("bp_hold_stable", {z_s_out, z_e_out, z_m_out}, cap);
    check("bp_hold_s", z_s_out, 1);
    check("bp_hold_e", z_e_out, 10'h382);
    check("bp_hold_m", z_m_out, 0);
    @(posedge clk);
    #1;
    force_ready = 1'b1;
    wait_idle("bp_release");

    // Reset in the middle of the right shifts of the denormalise case.
    send_beat(1'b0, 10'h37E, 24'h800000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_z_s", z_s_out, 0);
    check("midrst_z_e", z_e_out, 0);
    check("midrst_z_m", z_m_out, 0);
    @(posedge clk);
    #1;
    send_beat(1'b0, 10'd0, 24'h400000, 1'b1, 1'b0, 1'b0);
    wait_idle("after_midrst");

    // Randomized beats with random backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       ei = int'($urandom_range(0, 180)) - 300;
        1:       ei = int'($urandom_range(0, 40)) - 140;
        2:       ei = int'($urandom_range(0, 50)) - 10;
        default: ei = int'($urandom_range(0, 600)) - 300;
      endcase
      mm = 24'($urandom);
      mm = mm >> $urandom_range(0, 24);
      send_beat(1'($urandom), ei[9:0], mm, 1'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_bp = 1'b0;
    force_ready = 1'b1;
    @(posedge clk);
    #1;
    wait_idle("random_drain");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
